matrix_print_sequencer: RTL and testbench

Sequences one print job over memory read port A. Accepts a print request (mode + target matrix ID), claims port A via printer_active, and walks the matrix row-major. Each element is emitted, with separators, as tokens to the UART formatter over a valid/ready handshake. It sits between the print-request arbitration path and the UART text formatter, and drives the printer_id/row/col/active inputs of the system interconnect.

---
 rtl/matrix_print_sequencer_pkg.sv | 22 ++
 rtl/matrix_print_sequencer_addr_walker.sv | 41 ++++
 rtl/matrix_print_sequencer.sv | 176 +++++++++++++++++
 tb/tb_matrix_print_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_print_sequencer_pkg.sv
// Shared encodings for the matrix print sequencer: FSM states, token types, default size limit.
// Optional feature macro used by the top: PRINT_HEADER_EN.
package matrix_print_sequencer_pkg;

   localparam int MAX_DIM_DEF = 5;

   typedef enum logic [2:0] {
      PS_IDLE   = 3'd0,
      PS_LOOKUP = 3'd1,
      PS_HEADER = 3'd2,
      PS_WAIT   = 3'd3,
      PS_SEND   = 3'd4,
      PS_SEP    = 3'd5,
      PS_DONE   = 3'd6
   } ps_state_t;

   localparam logic [1:0] TOK_ELEM   = 2'd0;
   localparam logic [1:0] TOK_COLSEP = 2'd1;
   localparam logic [1:0] TOK_ROWEND = 2'd2;
   localparam logic [1:0] TOK_HDR    = 2'd3;

endpackage

// File: rtl/matrix_print_sequencer_addr_walker.sv
// Row-major row/col counters for the print sequencer, with last-column / last-row flags.
module matrix_print_sequencer_addr_walker #(
   parameter int DIM_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             col_inc,
   input  logic             row_inc,
   input  logic [DIM_W-1:0] m,
   input  logic [DIM_W-1:0] n,
   output logic [DIM_W-1:0] row,
   output logic [DIM_W-1:0] col,
   output logic             last_col,
   output logic             last_row
);

   logic [DIM_W-1:0] row_reg;
   logic [DIM_W-1:0] col_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_reg <= '0;
         col_reg <= '0;
      end else if (clear) begin
         row_reg <= '0;
         col_reg <= '0;
      end else if (row_inc) begin
         row_reg <= row_reg + DIM_W'(1);
         col_reg <= '0;
      end else if (col_inc) begin
         col_reg <= col_reg + DIM_W'(1);
      end
   end

   assign row      = row_reg;
   assign col      = col_reg;
   assign last_col = (col_reg == n - DIM_W'(1));
   assign last_row = (row_reg == m - DIM_W'(1));

endmodule

// File: rtl/matrix_print_sequencer.sv
// Walks one matrix row-major over memory port A and emits element/separator tokens.
// Optional header token (type 3, {m,n}) is built when PRINT_HEADER_EN is defined.
module matrix_print_sequencer
   import matrix_print_sequencer_pkg::*;
#(
   parameter int ID_W     = 7,
   parameter int DIM_W    = 4,
   parameter int DATA_W   = 32,
   parameter int MAX_DIM  = MAX_DIM_DEF,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              print_req,
   input  logic [3:0]        print_mode,
   input  logic [ID_W-1:0]   print_target_id,
   input  logic [DIM_W-1:0]  meta_m,
   input  logic [DIM_W-1:0]  meta_n,
   input  logic              meta_valid,
   input  logic [DATA_W-1:0] mem_data_a,
   output logic              printer_active,
   output logic [ID_W-1:0]   printer_id,
   output logic [DIM_W-1:0]  printer_row,
   output logic [DIM_W-1:0]  printer_col,
   output logic              tok_valid,
   input  logic              tok_ready,
   output logic [1:0]        tok_type,
   output logic [DATA_W-1:0] tok_data,
   output logic [3:0]        tok_mode,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);
   // WAIT holds READ_LAT+1 cycles: one for the registered address to reach the RAM, READ_LAT for its output.
   localparam logic [1:0] LAT_CNT = 2'(READ_LAT);
`ifdef PRINT_HEADER_EN
   localparam ps_state_t FIRST_STATE = PS_HEADER;
`else
   localparam ps_state_t FIRST_STATE = PS_WAIT;
`endif

   ps_state_t         state_reg, state_next;
   logic [ID_W-1:0]   id_reg;
   logic [3:0]        mode_reg;
   logic [DIM_W-1:0]  m_reg, n_reg;
   logic              err_reg;
   logic [DATA_W-1:0] data_reg;
   logic [1:0]        wait_cnt_reg;

   logic meta_bad;
   logic walk_clear, walk_col_inc, walk_row_inc;
   logic last_col, last_row;

   assign meta_bad = !meta_valid || (meta_m == '0) || (meta_n == '0) ||
                     (meta_m > DIM_MAX) || (meta_n > DIM_MAX);

   matrix_print_sequencer_addr_walker #(.DIM_W(DIM_W)) u_walker (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (walk_clear),
      .col_inc  (walk_col_inc),
      .row_inc  (walk_row_inc),
      .m        (m_reg),
      .n        (n_reg),
      .row      (printer_row),
      .col      (printer_col),
      .last_col (last_col),
      .last_row (last_row)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= PS_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         PS_IDLE:   if (print_req) state_next = PS_LOOKUP;
         PS_LOOKUP: state_next = meta_bad ? PS_DONE : FIRST_STATE;
`ifdef PRINT_HEADER_EN
         PS_HEADER: if (tok_ready) state_next = PS_WAIT;
`endif
         PS_WAIT:   if (wait_cnt_reg == LAT_CNT) state_next = PS_SEND;
         PS_SEND:   if (tok_ready) state_next = PS_SEP;
         PS_SEP:    if (tok_ready) state_next = (last_col && last_row) ? PS_DONE : PS_WAIT;
         PS_DONE:   state_next = PS_IDLE;
         default:   state_next = PS_IDLE;
      endcase
   end

   always_comb begin
      tok_valid      = 1'b0;
      tok_type       = TOK_ELEM;
      tok_data       = '0;
      printer_active = 1'b0;
      busy           = 1'b1;
      done           = 1'b0;
      err            = 1'b0;
      walk_clear     = 1'b0;
      walk_col_inc   = 1'b0;
      walk_row_inc   = 1'b0;
      case (state_reg)
         PS_IDLE: busy = 1'b0;
         PS_LOOKUP: begin
            printer_active = 1'b1;
            walk_clear     = 1'b1;
         end
`ifdef PRINT_HEADER_EN
         PS_HEADER: begin
            printer_active = 1'b1;
            tok_valid      = 1'b1;
            tok_type       = TOK_HDR;
            tok_data       = DATA_W'({m_reg, n_reg});
         end
`endif
         PS_WAIT: printer_active = 1'b1;
         PS_SEND: begin
            printer_active = 1'b1;
            tok_valid      = 1'b1;
            tok_type       = TOK_ELEM;
            tok_data       = data_reg;
         end
         PS_SEP: begin
            printer_active = 1'b1;
            tok_valid      = 1'b1;
            tok_type       = last_col ? TOK_ROWEND : TOK_COLSEP;
            walk_col_inc   = tok_ready && !last_col;
            walk_row_inc   = tok_ready && last_col && !last_row;
         end
         PS_DONE: begin
            done = 1'b1;
            err  = err_reg;
         end
         default: busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_reg       <= '0;
         mode_reg     <= '0;
         m_reg        <= '0;
         n_reg        <= '0;
         err_reg      <= 1'b0;
         data_reg     <= '0;
         wait_cnt_reg <= '0;
      end else begin
         if (state_reg == PS_IDLE && print_req) begin
            id_reg   <= print_target_id;
            mode_reg <= print_mode;
            err_reg  <= 1'b0;
         end
         if (state_reg == PS_LOOKUP) begin
            m_reg   <= meta_m;
            n_reg   <= meta_n;
            err_reg <= meta_bad;
         end
         if (state_reg == PS_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 2'd1;
            if (wait_cnt_reg == LAT_CNT) data_reg <= mem_data_a;
         end else begin
            wait_cnt_reg <= '0;
         end
      end
   end

   assign printer_id = id_reg;
   assign tok_mode   = mode_reg;

endmodule

// File: tb/tb_matrix_print_sequencer.sv
// Directed bench for matrix_print_sequencer: token streams, backpressure, error jobs, abort by reset.
// Header expectations are added when PRINT_HEADER_EN is defined.
module tb_matrix_print_sequencer;

   localparam int ID_W = 7, DIM_W = 4, DATA_W = 32;
`ifdef PRINT_HEADER_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              print_req = 1'b0;
   logic [3:0]        print_mode = '0;
   logic [ID_W-1:0]   print_target_id = '0;
   logic [DIM_W-1:0]  meta_m, meta_n;
   logic              meta_valid;
   logic [DATA_W-1:0] mem_data_a = '0;
   logic              printer_active;
   logic [ID_W-1:0]   printer_id;
   logic [DIM_W-1:0]  printer_row, printer_col;
   logic              tok_valid;
   logic              tok_ready = 1'b1;
   logic [1:0]        tok_type;
   logic [DATA_W-1:0] tok_data;
   logic [3:0]        tok_mode;
   logic              busy, done, err;

   matrix_print_sequencer dut (
      .clk(clk), .rst_n(rst_n), .print_req(print_req), .print_mode(print_mode),
      .print_target_id(print_target_id), .meta_m(meta_m), .meta_n(meta_n),
      .meta_valid(meta_valid), .mem_data_a(mem_data_a), .printer_active(printer_active),
      .printer_id(printer_id), .printer_row(printer_row), .printer_col(printer_col),
      .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type),
      .tok_data(tok_data), .tok_mode(tok_mode), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Matrix store: metadata per ID, element values per (ID,row,col), one-cycle registered read.
   function automatic logic [31:0] elem(input logic [6:0] id, input logic [3:0] r, input logic [3:0] c);
      case (id)
         7'd3:    return 32'(r) * 3 + 32'(c) + 1;
         7'd4:    return 32'hA000 + 32'(r) * 16 + 32'(c);
         7'd6:    return 32'hFFFF_FFFF;
         7'd7:    return 32'h10 + 32'(r) * 2 + 32'(c);
         default: return 32'hDEAD_0000;
      endcase
   endfunction

   always_comb begin
      meta_m = 4'd0; meta_n = 4'd0; meta_valid = 1'b0;
      case (printer_id)
         7'd3: begin meta_m = 4'd2; meta_n = 4'd3; meta_valid = 1'b1; end
         7'd4: begin meta_m = 4'd3; meta_n = 4'd3; meta_valid = 1'b1; end
         7'd5: begin meta_m = 4'd6; meta_n = 4'd2; meta_valid = 1'b1; end
         7'd6: begin meta_m = 4'd1; meta_n = 4'd1; meta_valid = 1'b1; end
         7'd7: begin meta_m = 4'd3; meta_n = 4'd2; meta_valid = 1'b1; end
         default: ;
      endcase
   end

   always @(posedge clk) mem_data_a <= elem(printer_id, printer_row, printer_col);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 0: ready always, 1: ready one cycle in three, 2: ready held low
   int ready_mode = 0;
   initial forever begin
      @(posedge clk); #1;
      tok_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ((cyc % 3) == 0) : 1'b0;
   end

   logic [1:0]  tq_type[$];
   logic [31:0] tq_data[$];
   int done_cnt = 0, err_cnt = 0, stall_viol = 0, active_viol = 0, done_cyc = 0;
   logic        prev_stall = 1'b0;
   logic [1:0]  prev_type = '0;
   logic [31:0] prev_data = '0;

   always @(negedge clk) begin
      if (rst_n && prev_stall && (!tok_valid || tok_type !== prev_type || tok_data !== prev_data))
         stall_viol <= stall_viol + 1;
      prev_stall <= rst_n && tok_valid && !tok_ready;
      prev_type  <= tok_type;
      prev_data  <= tok_data;
      if (tok_valid && tok_ready) begin
         tq_type.push_back(tok_type);
         tq_data.push_back(tok_data);
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
         if (err) err_cnt <= err_cnt + 1;
         if (printer_active) active_viol <= active_viol + 1;
      end
   end

   int checks = 0, errors = 0;
   int req_cyc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic run_job(input logic [6:0] id, input logic [3:0] mode);
      @(posedge clk); #1;
      print_req = 1'b1; print_target_id = id; print_mode = mode;
      req_cyc = cyc;
      @(posedge clk); #1;
      print_req = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      check({tag, "_done_timeout"}, 64'(ok), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_tokens(input string tag, input int start, input logic [1:0] et_in[$],
                               input logic [31:0] ed_in[$], input logic [31:0] hv);
      logic [1:0]  et[$];
      logic [31:0] ed[$];
      et = et_in; ed = ed_in;
      if (HDR) begin et.push_front(2'd3); ed.push_front(hv); end
      check({tag, "_tok_count"}, 64'(tq_type.size() - start), 64'(et.size()));
      for (int i = 0; i < et.size(); i++) begin
         if (start + i < tq_type.size()) begin
            check($sformatf("%s_type%0d", tag, i), 64'(tq_type[start + i]), 64'(et[i]));
            check($sformatf("%s_data%0d", tag, i), 64'(tq_data[start + i]), 64'(ed[i]));
         end
      end
   endtask

   initial begin
      logic [1:0]  t23[$];
      logic [31:0] d23[$];
      logic [1:0]  none_t[$];
      logic [31:0] none_d[$];
      int s, d0, e0, w;
      bit seen;
      t23 = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2};
      d23 = '{32'd1, 32'd0, 32'd2, 32'd0, 32'd3, 32'd0, 32'd4, 32'd0, 32'd5, 32'd0, 32'd6, 32'd0};

      // Reset state
      @(negedge clk);
      check("rst_active", 64'(printer_active), 64'd0);
      check("rst_valid",  64'(tok_valid), 64'd0);
      check("rst_busy",   64'(busy), 64'd0);
      check("rst_done",   64'(done), 64'd0);
      check("rst_err",    64'(err), 64'd0);
      check("rst_id",     64'(printer_id), 64'd0);
      check("rst_rowcol", 64'({printer_row, printer_col}), 64'd0);
      @(posedge clk); #1; rst_n = 1'b1;

      // 2x3 matrix, always ready
      s = tq_type.size(); d0 = done_cnt; e0 = err_cnt;
      run_job(7'd3, 4'h5);
      check("j1_busy", 64'(busy), 64'd1);
      check("j1_active", 64'(printer_active), 64'd1);
      check("j1_mode", 64'(tok_mode), 64'h5);
      wait_done("j1");
      check_tokens("j1", s, t23, d23, 32'h23);
      check("j1_done_cnt", 64'(done_cnt - d0), 64'd1);
      check("j1_err_cnt",  64'(err_cnt - e0), 64'd0);
      check("j1_active_at_done", 64'(active_viol), 64'd0);
      check("j1_idle_busy", 64'(busy), 64'd0);

      // Same job with ready one cycle in three
      ready_mode = 1;
      s = tq_type.size(); d0 = done_cnt;
      run_job(7'd3, 4'h2);
      wait_done("j2");
      ready_mode = 0;
      check_tokens("j2", s, t23, d23, 32'h23);
      check("j2_stall_stable", 64'(stall_viol), 64'd0);
      check("j2_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Unallocated ID: done+err two cycles after request, no tokens
      s = tq_type.size(); e0 = err_cnt;
      run_job(7'd9, 4'h1);
      wait_done("j3");
      check_tokens("j3", s, none_t, none_d, 32'h0);
      check("j3_latency", 64'(done_cyc - req_cyc), 64'd2);
      check("j3_err_cnt", 64'(err_cnt - e0), 64'd1);

      // m=6 exceeds MAX_DIM
      s = tq_type.size(); e0 = err_cnt;
      run_job(7'd5, 4'h1);
      wait_done("j4");
      check_tokens("j4", s, none_t, none_d, 32'h0);
      check("j4_err_cnt", 64'(err_cnt - e0), 64'd1);

      // 1x1 with all-ones element
      s = tq_type.size(); e0 = err_cnt;
      run_job(7'd6, 4'h3);
      wait_done("j5");
      check_tokens("j5", s, '{2'd0, 2'd2}, '{32'hFFFF_FFFF, 32'd0}, 32'h11);
      check("j5_err_cnt", 64'(err_cnt - e0), 64'd0);

      // Request mid-job is ignored
      s = tq_type.size(); d0 = done_cnt;
      run_job(7'd3, 4'h7);
      repeat (6) @(posedge clk);
      #1; print_req = 1'b1; print_target_id = 7'd4; print_mode = 4'hC;
      @(posedge clk); #1; print_req = 1'b0;
      check("j6_id_kept", 64'(printer_id), 64'd3);
      check("j6_mode_kept", 64'(tok_mode), 64'h7);
      wait_done("j6");
      check_tokens("j6", s, t23, d23, 32'h23);
      check("j6_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Reset while a token is stalled in SEND
      ready_mode = 2;
      d0 = done_cnt;
      run_job(7'd3, 4'h9);
      seen = 1'b0; w = 0;
      while (!seen && w < 50) begin
         @(negedge clk); w++;
         if (tok_valid && tok_type == 2'd0) seen = 1'b1;
      end
      check("j7_reached_send", 64'(seen), 64'd1);
      @(posedge clk); #2; rst_n = 1'b0; #1;
      check("j7_rst_valid",  64'(tok_valid), 64'd0);
      check("j7_rst_active", 64'(printer_active), 64'd0);
      check("j7_rst_busy",   64'(busy), 64'd0);
      check("j7_rst_id",     64'(printer_id), 64'd0);
      check("j7_rst_rowcol", 64'({printer_row, printer_col}), 64'd0);
      check("j7_rst_mode",   64'(tok_mode), 64'd0);
      check("j7_rst_done",   64'(done), 64'd0);
      @(posedge clk); #1; rst_n = 1'b1; ready_mode = 0;
      check("j7_no_done", 64'(done_cnt - d0), 64'd0);

      // Clean restart after abort
      s = tq_type.size();
      run_job(7'd6, 4'h4);
      wait_done("j8");
      check_tokens("j8", s, '{2'd0, 2'd2}, '{32'hFFFF_FFFF, 32'd0}, 32'h11);

      // 3x2 matrix
      s = tq_type.size();
      run_job(7'd7, 4'h6);
      wait_done("j9");
      check_tokens("j9", s,
         '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2},
         '{32'h10, 32'd0, 32'h11, 32'd0, 32'h12, 32'd0, 32'h13, 32'd0, 32'h14, 32'd0, 32'h15, 32'd0},
         32'h32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
